// File: rtl/wb_writer_pkg.sv
// Shared encodings for the register-file writeback unit: write-enable levels,
// load funct3 codes and the round-robin pointer.
package wb_writer_pkg;

    localparam int XLEN = 32;

    localparam logic REGWE_WRITE = 1'b1;
    localparam logic REGWE_READ  = 1'b0;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

    typedef enum logic {
        RR_EX  = 1'b0,
        RR_LSU = 1'b1
    } rr_e;

    // Undefined funct3 codes behave as LW, so they need word alignment.
    function automatic logic load_misaligned(input logic [2:0] funct3, input logic [1:0] offset);
        case (funct3)
            LB, LBU: return 1'b0;
            LH, LHU: return offset[0];
            default: return offset != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/wb_writer_if.sv
// Result handshakes, scoreboard query/issue and register-file write port of wb_writer.
interface wb_writer_if;
    import wb_writer_pkg::*;

    logic            ex_valid;
    logic            ex_ready;
    logic [4:0]      ex_rd;
    logic [XLEN-1:0] ex_data;

    logic            lsu_valid;
    logic            lsu_ready;
    logic [4:0]      lsu_rd;
    logic [2:0]      lsu_funct3;
    logic [1:0]      lsu_offset;
    logic [XLEN-1:0] lsu_rdata;

    logic            iss_en;
    logic [4:0]      iss_rd;
    logic [4:0]      rs1_addr;
    logic [4:0]      rs2_addr;
    logic            rs1_busy;
    logic            rs2_busy;

    logic            regs_w_en;
    logic [4:0]      rd_addr;
    logic [XLEN-1:0] rd_data;
    logic            misalign_err;

    modport master (
        output ex_valid, ex_rd, ex_data,
        output lsu_valid, lsu_rd, lsu_funct3, lsu_offset, lsu_rdata,
        output iss_en, iss_rd, rs1_addr, rs2_addr,
        input  ex_ready, lsu_ready, rs1_busy, rs2_busy,
        input  regs_w_en, rd_addr, rd_data, misalign_err
    );

    modport slave (
        input  ex_valid, ex_rd, ex_data,
        input  lsu_valid, lsu_rd, lsu_funct3, lsu_offset, lsu_rdata,
        input  iss_en, iss_rd, rs1_addr, rs2_addr,
        output ex_ready, lsu_ready, rs1_busy, rs2_busy,
        output regs_w_en, rd_addr, rd_data, misalign_err
    );

endinterface

// File: rtl/wb_writer_load_ext.sv
// Combinational load alignment and sign/zero extension with misalignment flag;
// kept standalone so a store-to-load forwarding path can reuse it.
module load_ext
    import wb_writer_pkg::*;
(
    input  logic [2:0]      funct3,
    input  logic [1:0]      offset,
    input  logic [XLEN-1:0] rdata,
    output logic [XLEN-1:0] data,
    output logic            misalign
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (offset)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase

        half_sel = offset[1] ? rdata[31:16] : rdata[15:0];

        case (funct3)
            LB:      data = {{24{byte_sel[7]}}, byte_sel};
            LBU:     data = {24'd0, byte_sel};
            LH:      data = {{16{half_sel[15]}}, half_sel};
            LHU:     data = {16'd0, half_sel};
            default: data = rdata;
        endcase

        misalign = load_misaligned(funct3, offset);
    end

endmodule

// File: rtl/wb_writer.sv
// Writeback unit: arbitrates EX and LSU results onto the register-file write
// port (one registered write per cycle) and tracks pending writes for decode.
module wb_writer
    import wb_writer_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    wb_writer_if.slave  bus
);

    rr_e             rr;
    logic            ex_go;
    logic            lsu_go;
    logic            contested;
    logic [XLEN-1:0] ld_data;
    logic            ld_misalign;
    logic [31:0]     pending;
    logic [31:0]     pending_nxt;

    load_ext u_load_ext (
        .funct3   (bus.lsu_funct3),
        .offset   (bus.lsu_offset),
        .rdata    (bus.lsu_rdata),
        .data     (ld_data),
        .misalign (ld_misalign)
    );

    // Ready is derived only from the other source's valid and the pointer,
    // so a source never sees its own valid looped back into its ready.
    assign bus.ex_ready  = !bus.lsu_valid || (rr == RR_EX);
    assign bus.lsu_ready = !bus.ex_valid  || (rr == RR_LSU);

    assign ex_go     = bus.ex_valid  && bus.ex_ready;
    assign lsu_go    = bus.lsu_valid && bus.lsu_ready;
    assign contested = bus.ex_valid  && bus.lsu_valid;

    assign bus.rs1_busy = pending[bus.rs1_addr];
    assign bus.rs2_busy = pending[bus.rs2_addr];

    // Issue is applied last so a new producer wins over a same-edge retire.
    always_comb begin
        pending_nxt = pending;
        if (bus.regs_w_en == REGWE_WRITE) begin
            pending_nxt[bus.rd_addr] = 1'b0;
        end
        if (lsu_go && ld_misalign) begin
            pending_nxt[bus.lsu_rd] = 1'b0;
        end
        if (bus.iss_en && (bus.iss_rd != 5'd0)) begin
            pending_nxt[bus.iss_rd] = 1'b1;
        end
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr               <= RR_LSU;
            pending          <= '0;
            bus.regs_w_en    <= REGWE_READ;
            bus.rd_addr      <= '0;
            bus.rd_data      <= '0;
            bus.misalign_err <= 1'b0;
        end else begin
            pending          <= pending_nxt;
            bus.misalign_err <= lsu_go && ld_misalign;
            bus.regs_w_en    <= REGWE_READ;

            // Hand priority to the loser after a contested cycle.
            if (contested) begin
                rr <= (rr == RR_LSU) ? RR_EX : RR_LSU;
            end

            if (ex_go && (bus.ex_rd != 5'd0)) begin
                bus.regs_w_en <= REGWE_WRITE;
                bus.rd_addr   <= bus.ex_rd;
                bus.rd_data   <= bus.ex_data;
            end else if (lsu_go && !ld_misalign && (bus.lsu_rd != 5'd0)) begin
                bus.regs_w_en <= REGWE_WRITE;
                bus.rd_addr   <= bus.lsu_rd;
                bus.rd_data   <= ld_data;
            end
        end
    end

endmodule

// File: doc/wb_writer.md
# wb_writer

Writeback unit on the write side of the integer register file. Accepts completed results from the execute stage (ALU) and the load/store unit (load data) through valid/ready handshakes, extends and aligns load data, and arbitrates one registered write per cycle onto the register file write port. It also keeps a 32-entry pending-write scoreboard so the decode stage can stall on operands whose producer has not yet written back.

## Interface
Parameters:
- None. Widths are fixed by RV32I: XLEN 32, 5-bit register addresses.

Ports:
- `clk` in 1: single clock; all state updates on posedge.
- `rst_n` in 1: asynchronous, active-low reset.
- `ex_valid` in 1: execute result available.
- `ex_ready` out 1: execute result accepted this cycle when `ex_valid && ex_ready`.
- `ex_rd` in 5: destination register of the execute result.
- `ex_data` in 32: ALU result.
- `lsu_valid` in 1: load result available.
- `lsu_ready` out 1: load result accepted this cycle when `lsu_valid && lsu_ready`.
- `lsu_rd` in 5: destination register of the load.
- `lsu_funct3` in 3: load type (LB 000, LH 001, LW 010, LBU 100, LHU 101).
- `lsu_offset` in 2: byte address bits [1:0].
- `lsu_rdata` in 32: raw aligned memory word.
- `iss_en` in 1: decode issues an instruction that writes `iss_rd`.
- `iss_rd` in 5: destination register of the issuing instruction.
- `rs1_addr` in 5: decode operand address to query.
- `rs2_addr` in 5: decode operand address to query.
- `rs1_busy` out 1: `rs1_addr` has a pending write; combinational.
- `rs2_busy` out 1: `rs2_addr` has a pending write; combinational.
- `regs_w_en` out 1: register file write enable; registered.
- `rd_addr` out 5: register file write address; registered.
- `rd_data` out 32: register file write data; registered.
- `misalign_err` out 1: one-cycle pulse for a dropped misaligned load; registered.

## Operation
- **Grant.** At most one result is accepted per cycle.
  - Only one source valid: that source is granted.
  - Both sources valid: round-robin pointer `rr` picks the winner. `rr` resets to LSU. After a contested grant, `rr` points to the loser. `rr` does not change on uncontested cycles.
  - `ex_ready` = `!lsu_valid || rr==EX`. `lsu_ready` = `!ex_valid || rr==LSU`. Ready never depends on the same source's own valid.
- **Load formatting.**
  - LB/LBU select byte `lsu_offset`. LH/LHU select halfword `lsu_offset[1]`. LW takes the whole word.
  - LB and LH sign-extend. LBU and LHU zero-extend.
  - Misaligned cases: LH/LHU with `offset[0]=1`, or LW with `offset!=0`. The load is still accepted, but no write occurs and `misalign_err` pulses.
  - Undefined funct3 values are treated as LW.
- **Output register.**
  - An accepted result with a nonzero rd and no misalignment registers `regs_w_en=REGWE_WRITE`, `rd_addr`, and `rd_data`.
  - Otherwise `regs_w_en` is 0. In that case `rd_addr`/`rd_data` hold their previous values.
  - Writes to x0 are accepted and silently dropped.
- **Scoreboard** `pending[31:1]`. `pending[0]` is constant 0.
  - Set: `iss_en && iss_rd!=0` sets `pending[iss_rd]` at the edge.
  - Clear: `regs_w_en` clears `pending[rd_addr]` at the edge where the register file captures the write.
  - Set and clear on the same register at the same edge: set wins (newer producer).
  - A dropped misaligned load clears `pending[lsu_rd]` at its acceptance edge.
  - `rsN_busy` = `pending[rsN_addr]`.

## Timing
- Reset values: `regs_w_en` 0, `rd_addr` 0, `rd_data` 0, `misalign_err` 0, `pending` all 0, `rr`=LSU.
- Reset is asynchronous mid-operation. A result in flight on the output register is lost, and the handshake sources must re-present it.
- Latency:
  - Handshake accepted at edge N → `regs_w_en` high during cycle N+1.
  - The register file writes at edge N+1.
  - The pending bit clears at edge N+1, so `rsN_busy` first reads 0 in cycle N+2, when the register file read returns the new value.
- Throughput: one write per cycle sustained. There is no backpressure from the register file.
- A source's valid, rd, and data must stay stable while valid is high and ready is low.

## Structure
- Add to `header.v`: `REGWE_WRITE`/`REGWE_READ`, load funct3 codes `LB`/`LH`/`LW`/`LBU`/`LHU`, and `RR_EX`/`RR_LSU` encodings.
- One sub-module, `load_ext`: combinational load extension/alignment plus the misalign flag, reusable by a later store-to-load forwarding path.
- The scoreboard and arbiter stay inline in `wb_writer`.

## Test plan
- **Reset.** Assert `rst_n`=0 mid-write → all outputs 0 and busy flags 0 immediately, without waiting for a clock edge.
- **Single EX write.** `ex_valid`, `ex_rd`=5, `ex_data`=0x1234_5678 at edge N → cycle N+1 shows `regs_w_en`=1, `rd_addr`=5, `rd_data`=0x1234_5678. `iss_en` on x5 before N → `rs1_busy`(rs1=5) is 1 through cycle N+1 and 0 in cycle N+2.
- **Load extension.** `lsu_rdata`=0x80FF_7F01:
  - LB offset 3 → 0xFFFF_FF80.
  - LBU offset 3 → 0x0000_0080.
  - LH offset 2 → 0xFFFF_80FF.
  - LHU offset 0 → 0x0000_7F01.
- **Misaligned load.** LW at offset 2 → `lsu_ready`=1, no write, `misalign_err` pulse for 1 cycle, `pending[lsu_rd]` cleared.
- **Contention.** Both sources valid for 4 cycles starting right after reset → grants LSU, EX, LSU, EX. Losers' ready is 0 and their data stays held.
- **x0 and scoreboard overlap.**
  - `ex_rd`=0 → `regs_w_en` stays 0.
  - `iss_en` on x7 at the same edge `regs_w_en` writes x7 → `pending[7]` remains 1.
